// File: rtl/branch_predict_resolve_pkg.sv
// Shared encodings and sizing helpers for the branch predictor / resolver.
package branch_predict_resolve_pkg;

    typedef enum logic [2:0] {
        OP_BEQ      = 3'b000,
        OP_BNE      = 3'b001,
        OP_JAL_JALR = 3'b010,
        OP_BLT      = 3'b100,
        OP_BGE      = 3'b101,
        OP_BLTU     = 3'b110,
        OP_BGEU     = 3'b111
    } br_op_e;

    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Tag covers everything above the word offset and the index.
    function automatic int tag_width(input int entries);
        return 32 - $clog2(entries) - 2;
    endfunction

    function automatic int ctr_reset_val(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_branch_cond.sv
// Pure combinational branch condition evaluation for the EX stage.
module branch_predict_resolve_branch_cond
    import branch_predict_resolve_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        taken_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (data1_i == data2_i);
    assign lt_s = ($signed(data1_i) < $signed(data2_i));
    assign lt_u = (data1_i < data2_i);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_BEQ:      taken_o = eq;
            OP_BNE:      taken_o = !eq;
            OP_BLT:      taken_o = lt_s;
            OP_BGE:      taken_o = !lt_s;
            OP_BLTU:     taken_o = lt_u;
            OP_BGEU:     taken_o = !lt_u;
            OP_JAL_JALR: taken_o = 1'b1;
            default:     taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Bimodal + BTB fetch predictor with EX-stage branch resolution and
// saturating performance counters.
module branch_predict_resolve
    import branch_predict_resolve_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_WIDTH   = 2,
    parameter int PERF_WIDTH  = 32
)
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  ex_valid,
    input  logic                  ex_is_ctrl,
    input  logic [2:0]            ex_op,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_data1,
    input  logic [31:0]           ex_data2,
    input  logic [31:0]           ex_target,
    input  logic                  ex_pred_taken,
    input  logic [31:0]           ex_pred_target,
    output logic                  ex_taken,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [PERF_WIDTH-1:0] perf_branches,
    output logic [PERF_WIDTH-1:0] perf_mispred
);

    localparam int BHT_IW = idx_width(BHT_ENTRIES);
    localparam int BTB_IW = idx_width(BTB_ENTRIES);
    localparam int TAG_W  = tag_width(BTB_ENTRIES);
    localparam logic [CTR_WIDTH-1:0]  CTR_RST  = CTR_WIDTH'(ctr_reset_val(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = {PERF_WIDTH{1'b1}};

    logic [CTR_WIDTH-1:0] bht_q        [BHT_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_q    [BTB_ENTRIES];
    logic [31:0]          btb_target_q [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [BTB_ENTRIES-1:0] btb_jump_q;

    logic [PERF_WIDTH-1:0] perf_branches_q, perf_branches_d;
    logic [PERF_WIDTH-1:0] perf_mispred_q,  perf_mispred_d;

    // ---------------- predict (IF) ----------------
    logic [BHT_IW-1:0] if_bht_idx;
    logic [BTB_IW-1:0] if_btb_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;

    assign if_bht_idx = if_pc[BHT_IW+1:2];
    assign if_btb_idx = if_pc[BTB_IW+1:2];
    assign if_tag     = if_pc[31:BTB_IW+2];
    assign if_hit     = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);

    assign pred_taken  = if_hit && (btb_jump_q[if_btb_idx] || bht_q[if_bht_idx][CTR_WIDTH-1]);
    assign pred_target = if_hit ? btb_target_q[if_btb_idx] : (if_pc + 32'd4);

    // ---------------- resolve (EX) ----------------
    logic cond_taken;
    logic ctrl_ok;

    branch_predict_resolve_branch_cond u_branch_cond (
        .op_i    (ex_op),
        .data1_i (ex_data1),
        .data2_i (ex_data2),
        .taken_o (cond_taken)
    );

    assign ctrl_ok     = ex_valid && ex_is_ctrl;
    assign ex_taken    = ctrl_ok && cond_taken;
    // Held low while in reset so flush logic never sees a spurious request.
    assign mispredict  = RESET_N && ctrl_ok &&
                         ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : (ex_pc + 32'd4);

    // ---------------- update ----------------
    logic [BHT_IW-1:0]    ex_bht_idx;
    logic [BTB_IW-1:0]    ex_btb_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 is_jump;
    logic                 bht_we;
    logic                 btb_we;
    logic [CTR_WIDTH-1:0] ctr_cur;
    logic [CTR_WIDTH-1:0] ctr_d;

    assign ex_bht_idx = ex_pc[BHT_IW+1:2];
    assign ex_btb_idx = ex_pc[BTB_IW+1:2];
    assign ex_tag     = ex_pc[31:BTB_IW+2];
    assign is_jump    = (ex_op == OP_JAL_JALR);
    assign bht_we     = ctrl_ok && !is_jump;
    assign btb_we     = ctrl_ok && ex_taken;
    assign ctr_cur    = bht_q[ex_bht_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (ex_taken) begin
            if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 1'b1;
        end else begin
            if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
        end
    end

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (ctrl_ok && (perf_branches_q != PERF_MAX))
            perf_branches_d = perf_branches_q + 1'b1;
        if (mispredict && (perf_mispred_q != PERF_MAX))
            perf_mispred_d = perf_mispred_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RST;
        end else if (bht_we) begin
            bht_q[ex_bht_idx] <= ctr_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btb_valid_q <= '0;
            btb_jump_q  <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (btb_we) begin
            btb_valid_q[ex_btb_idx]  <= 1'b1;
            btb_jump_q[ex_btb_idx]   <= is_jump;
            btb_tag_q[ex_btb_idx]    <= ex_tag;
            btb_target_q[ex_btb_idx] <= ex_target;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_mispred  = perf_mispred_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor compares.
module tb_branch_predict_resolve;

    localparam int PW = 6;
    localparam int PMAX = (1 << PW) - 1;

    logic          CLK, RESET_N;
    logic [31:0]   if_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          ex_valid, ex_is_ctrl;
    logic [2:0]    ex_op;
    logic [31:0]   ex_pc, ex_data1, ex_data2, ex_target, ex_pred_target;
    logic          ex_pred_taken;
    logic          ex_taken, mispredict;
    logic [31:0]   redirect_pc;
    logic [PW-1:0] perf_branches, perf_mispred;

    branch_predict_resolve #(
        .BHT_ENTRIES(64), .BTB_ENTRIES(16), .CTR_WIDTH(2), .PERF_WIDTH(PW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_op(ex_op),
        .ex_pc(ex_pc), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_taken(ex_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    int          m_bht [64];
    bit          m_btb_v [16];
    bit          m_btb_j [16];
    logic [31:0] m_btb_pc [16];
    logic [31:0] m_btb_tgt [16];
    int          m_pb, m_pm;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_btb_v[i] = 0; m_btb_j[i] = 0; m_btb_pc[i] = 0; m_btb_tgt[i] = 0;
        end
        m_pb = 0; m_pm = 0;
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int bi, hi;
        bit hit;
        bi  = int'((pc / 4) % 16);
        hi  = int'((pc / 4) % 64);
        hit = m_btb_v[bi] && (m_btb_pc[bi] / 64 == pc / 64);
        t   = hit && (m_btb_j[bi] || m_bht[hi] >= 2);
        tg  = hit ? m_btb_tgt[bi] : pc + 32'd4;
    endfunction

    function automatic bit model_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint ua, ub;
        sa = a; sb = b;
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return 1'b1;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        pt;
        logic [31:0] ptg;
        logic        tk;
        logic        mp;
        logic [31:0] rd;
        int          pb;
        int          pm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pred_taken",    32'(pred_taken),    32'(e.pt));
            chk("pred_target",   pred_target,        e.ptg);
            chk("ex_taken",      32'(ex_taken),      32'(e.tk));
            chk("mispredict",    32'(mispredict),    32'(e.mp));
            chk("redirect_pc",   redirect_pc,        e.rd);
            chk("perf_branches", 32'(perf_branches), 32'(e.pb));
            chk("perf_mispred",  32'(perf_mispred),  32'(e.pm));
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit rst_n, input logic [31:0] ipc, input bit v, input bit c,
                         input logic [2:0] op, input logic [31:0] pc, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] tgt, input bit ppt,
                         input logic [31:0] pptg);
        exp_t e;
        bit tk, mp;
        int hi, bi;
        @(posedge CLK);
        #1;
        RESET_N = rst_n;
        if_pc = ipc; ex_valid = v; ex_is_ctrl = c; ex_op = op; ex_pc = pc;
        ex_data1 = d1; ex_data2 = d2; ex_target = tgt;
        ex_pred_taken = ppt; ex_pred_target = pptg;
        if (!rst_n) model_reset();
        model_pred(ipc, e.pt, e.ptg);
        tk = v && c && model_cond(op, d1, d2);
        mp = rst_n && v && c && ((tk != ppt) || (tk && tgt != pptg));
        e.tk = tk; e.mp = mp;
        e.rd = tk ? tgt : pc + 32'd4;
        e.pb = m_pb; e.pm = m_pm;
        q.push_back(e);
        if (rst_n && v && c) begin
            hi = int'((pc / 4) % 64);
            bi = int'((pc / 4) % 16);
            if (op != 3'd2) m_bht[hi] = tk ? ((m_bht[hi] < 3) ? m_bht[hi] + 1 : 3)
                                           : ((m_bht[hi] > 0) ? m_bht[hi] - 1 : 0);
            if (tk) begin
                m_btb_v[bi] = 1; m_btb_pc[bi] = pc; m_btb_tgt[bi] = tgt; m_btb_j[bi] = (op == 3'd2);
            end
            if (m_pb < PMAX) m_pb++;
            if (mp && m_pm < PMAX) m_pm++;
        end
    endtask

    // Issue an instruction whose carried prediction is what the predictor would say.
    task automatic issue_pred(input logic [31:0] ipc, input logic [2:0] op, input logic [31:0] pc,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tgt);
        logic t;
        logic [31:0] tg;
        model_pred(pc, t, tg);
        issue(1, ipc, 1, 1, op, pc, d1, d2, tgt, t, tg);
    endtask

    function automatic logic [31:0] rnd_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return 32'h1000 + ($urandom_range(0, 127) << 2);
    endfunction

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'(int'($urandom_range(0, 3)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, pc, tgt, ptg;
        logic        pt;
        RESET_N = 1'b0;
        if_pc = 0; ex_valid = 0; ex_is_ctrl = 0; ex_op = 0; ex_pc = 0;
        ex_data1 = 0; ex_data2 = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        model_reset();

        // reset: outputs quiet even with a mispredicting instruction in EX
        issue(0, 32'h100, 1, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h180, 0, 32'h204);
        issue(0, 32'h100, 1, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h180, 0, 32'h204);
        issue(1, 32'h100, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);

        // BLT signed taken from cold, then BLTU same operands not taken
        issue(1, 32'h100, 1, 1, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h180, 0, 32'h204);
        issue(1, 32'h200, 1, 1, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h180, 1, 32'h180);
        issue(1, 32'h200, 0, 1, 3'd4, 32'h200, 0, 0, 0, 0, 0);

        // BEQ saturate then one not-taken
        for (int i = 0; i < 4; i++) issue_pred(32'h300, 3'd0, 32'h300, 32'd5, 32'd5, 32'h340);
        issue_pred(32'h300, 3'd0, 32'h300, 32'd5, 32'd6, 32'h340);
        issue(1, 32'h300, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);

        // JAL alias replacement
        issue_pred(32'h400, 3'd2, 32'h400, 0, 0, 32'h800);
        issue_pred(32'h400, 3'd2, 32'h440, 0, 0, 32'hA00);
        issue(1, 32'h400, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);
        issue(1, 32'h440, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);

        // no update when not valid / not control; undefined op is not taken
        issue(1, 32'h300, 0, 1, 3'd0, 32'h300, 1, 1, 32'h999, 0, 0);
        issue(1, 32'h300, 1, 0, 3'd2, 32'h300, 1, 1, 32'h999, 0, 0);
        issue(1, 32'h300, 1, 1, 3'd3, 32'h300, 1, 1, 32'h999, 1, 32'h999);
        issue(1, 32'h300, 1, 1, 3'd2, 32'hFFFF_FFFC, 0, 0, 32'h10, 1, 32'h10);

        // reset pulsed mid-stream with updates pending
        issue(0, 32'h300, 1, 1, 3'd0, 32'h300, 1, 1, 32'h340, 0, 0);
        issue(1, 32'h300, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);
        issue(1, 32'h400, 0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0);

        // randomized traffic, one reset pulse in the middle
        for (int n = 0; n < 500; n++) begin
            pc  = rnd_pc();
            tgt = ($urandom_range(0, 3) == 0) ? rnd_pc() : 32'h2000 + ($urandom_range(0, 63) << 2);
            a   = rnd_data();
            b   = ($urandom_range(0, 3) == 0) ? a : rnd_data();
            if ($urandom_range(0, 1) == 0) model_pred(pc, pt, ptg);
            else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = ($urandom_range(0, 1) == 0) ? tgt : rnd_pc();
            end
            issue((n < 250 || n > 252), ($urandom_range(0, 1) == 0) ? pc : rnd_pc(),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0),
                  3'($urandom_range(0, 7)), pc, a, b, tgt, pt, ptg);
        end

        repeat (3) @(posedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never compared", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
